image_frame_buffer: RTL and testbench
=====================================

// Module: image_frame_buffer
// PURPOSE
// Parametrised ping-pong frame buffer. Successor to the single-bank, read-only image ROM.
// A pixel stream writer fills the back bank while the display reads the front bank at random addresses.
// Banks swap only on a display frame_sync pulse, and only once a full back frame is pending, so the display never sees tearing.
// Sits between the camera/decoder pixel stream and the VGA timing/address generator.
// PARAMETERS
// IMG_W      320             frame width in pixels
// IMG_H      240             frame height in pixels
// PIX_W      12              bits per pixel (RGB444 default)
// INIT_FILE  "image_data.hex" $readmemh image preloaded into bank 0; "" = no preload
// Derived:   N = IMG_W*IMG_H; ADDR_W = $clog2(N); storage = 2*N words of PIX_W
// PORTS
// clk            in   1       system clock, all logic on rising edge
// rst_n          in   1       asynchronous active-low reset
// wr_valid       in   1       write pixel valid
// wr_ready       out  1       buffer can accept a write pixel
// wr_sof         in   1       accepted beat is the first pixel of a frame
// wr_data        in   PIX_W   write pixel
// rd_en          in   1       read request
// rd_addr        in   ADDR_W  read pixel address, y*IMG_W+x
// rd_data        out  PIX_W   read pixel, registered
// rd_valid       out  1       rd_data valid
// frame_sync     in   1       one-cycle display frame boundary pulse (vsync edge)
// rd_bank        out  1       bank currently displayed
// frame_pending  out  1       complete frame waiting in back bank
// sof_err        out  1       sticky: wr_sof arrived mid-frame
// BEHAVIOUR
// - Reset values: rd_bank=0 (write bank=1), wr_addr=0, frame_pending=0, wr_ready=1, rd_data=0, rd_valid=0, sof_err=0. RAM contents are not reset.
// - Reset asserted mid-frame discards the partial frame.
// - Write accept: wr_valid&&wr_ready. The pixel goes to bank ~rd_bank at wr_addr, or at 0 if wr_sof is set.
// - After each accept, wr_addr = (sof ? 1 : wr_addr+1).
// - wr_sof accepted with wr_addr!=0: the frame restarts at 0 and sof_err sets. sof_err stays set until reset.
// - Frame complete: the accepted beat lands at address N-1. Next cycle: frame_pending=1, wr_ready=0, wr_addr=0.
// - Writes are back-pressured (wr_ready=0) while frame_pending=1. No overwrite of a finished back frame.
// - Swap: frame_sync && frame_pending (registered value) -> next edge rd_bank toggles, frame_pending=0, wr_ready=1.
// - frame_sync with frame_pending=0: no swap; the current front frame is redisplayed.
// - Completion beat and frame_sync in the same cycle: no swap that cycle (pending not yet set). Swap occurs on the next frame_sync.
// - Read: rd_en -> rd_data=mem[rd_bank][rd_addr] and rd_valid=1 on the next edge (1-cycle latency).
// - rd_en=0 -> rd_valid=0 and rd_data holds its value.
// - rd_addr>=N: rd_data=0, rd_valid=1, no wrap.
// - A read issued in the swap cycle uses the old rd_bank. The first read after the edge uses the new bank.
// - No read/write collision is possible: the read and write banks always differ.
// - RAM inferred as simple dual-port BRAM. Bank select is the address MSB (write: {~rd_bank,wr_addr}, read: {rd_bank,rd_addr}).
// TESTING
// (bench uses IMG_W=4, IMG_H=2, PIX_W=12, N=8, INIT_FILE="")
// 1 Reset, write 8 px 0x101..0x108 with sof on first -> frame_pending=1, wr_ready=0 cycle after 8th beat; rd addr 0 still bank 0.
// 2 Pulse frame_sync after 1 -> rd_bank=1, pending=0, wr_ready=1; reads addr 0..7 return 0x101..0x108, 1-cycle latency.
// 3 Hold wr_valid while pending, write 0xFFF -> not accepted; data read after next swap unchanged from new frame.
// 4 sof at beat 3 of a frame -> sof_err=1; that pixel lands at addr 0; frame completes after 8 more beats.
// 5 frame_sync in the same cycle as 8th beat -> no swap; swap on next frame_sync. rd_addr=9 -> rd_data=0, rd_valid=1.
// 6 Assert rst_n=0 mid-frame (beat 5) -> all outputs take reset values asynchronously; next full frame writes bank 1 correctly.

Source files
------------

// File: rtl/image_frame_buffer_if.sv
// Bus bundle for the ping-pong frame buffer: pixel write stream, random-access
// display read port and frame/bank status.
interface image_frame_buffer_if #(
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 17
);
    // Write stream: a beat transfers on a rising edge where wr_valid && wr_ready;
    // wr_sof/wr_data are sampled only on that edge, and the writer keeps the beat
    // stable until it is taken. Reads have no back-pressure: rd_en returns
    // rd_data with rd_valid one edge later.
    logic             wr_valid;
    logic             wr_ready;
    logic             wr_sof;
    logic [PIX_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              rd_valid;
    logic             frame_sync;
    logic             rd_bank;
    logic             frame_pending;
    logic             sof_err;

    modport master (
        output wr_valid, wr_sof, wr_data, rd_en, rd_addr, frame_sync,
        input  wr_ready, rd_data, rd_valid, rd_bank, frame_pending, sof_err
    );

    modport slave (
        input  wr_valid, wr_sof, wr_data, rd_en, rd_addr, frame_sync,
        output wr_ready, rd_data, rd_valid, rd_bank, frame_pending, sof_err
    );
endinterface

// File: rtl/image_frame_buffer.sv
// Ping-pong frame buffer: the writer fills the back bank while the display reads
// the front bank; banks swap on frame_sync only once a full back frame is pending.
module image_frame_buffer #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 240,
    parameter int PIX_W     = 12,
    parameter     INIT_FILE = "image_data.hex"
) (
    input  logic clk,
    input  logic rst_n,
    image_frame_buffer_if.slave bus
);
    localparam int N      = IMG_W * IMG_H;
    localparam int ADDR_W = $clog2(N);
    // Bank select is the address MSB, so each bank is padded to a power of two.
    localparam int DEPTH  = 2 * (2 ** ADDR_W);
    localparam logic [ADDR_W:0]   N_EXT = (ADDR_W + 1)'(N);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N - 1);

    logic [PIX_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wr_idx;
    logic              accept;
    logic              rd_bank_q;
    logic              pending_q;
    logic              sof_err_q;
    logic              rd_valid_q;
    logic [PIX_W-1:0]  rd_data_q;

    assign accept = bus.wr_valid && !pending_q;
    assign wr_idx = bus.wr_sof ? '0 : wr_addr;

    assign bus.wr_ready      = !pending_q;
    assign bus.frame_pending = pending_q;
    assign bus.rd_bank       = rd_bank_q;
    assign bus.sof_err       = sof_err_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_data       = rd_data_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[{~rd_bank_q, wr_idx}] <= bus.wr_data;
        end
    end

    // A pending frame blocks writes, so completion and swap never share an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr   <= '0;
            pending_q <= 1'b0;
            rd_bank_q <= 1'b0;
            sof_err_q <= 1'b0;
        end else if (accept) begin
            if (bus.wr_sof && (wr_addr != '0)) begin
                sof_err_q <= 1'b1;
            end
            if (wr_idx == LAST) begin
                pending_q <= 1'b1;
                wr_addr   <= '0;
            end else begin
                wr_addr <= wr_idx + 1'b1;
            end
        end else if (bus.frame_sync && pending_q) begin
            rd_bank_q <= ~rd_bank_q;
            pending_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else if (bus.rd_en) begin
            rd_valid_q <= 1'b1;
            if ({1'b0, bus.rd_addr} < N_EXT) begin
                rd_data_q <= mem[{rd_bank_q, bus.rd_addr}];
            end else begin
                rd_data_q <= '0;
            end
        end else begin
            rd_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_image_frame_buffer.sv
// Bench for image_frame_buffer: directed frame/swap scenarios plus random traffic,
// checked against a frame-level model; a 3x3 instance covers out-of-range reads.
module tb_image_frame_buffer;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;
    localparam int PIX_W  = 12;
    localparam int N      = 8;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    image_frame_buffer_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();
    image_frame_buffer_if #(.PIX_W(PIX_W), .ADDR_W(4))      bus2 ();

    image_frame_buffer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .INIT_FILE("")
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    image_frame_buffer #(
        .IMG_W(3), .IMG_H(3), .PIX_W(PIX_W), .INIT_FILE("")
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    // Reference model: two banks of pixels with per-pixel "written" flags.
    logic [PIX_W-1:0] m_mem   [2][N];
    bit               m_known [2][N];
    logic             m_bank;
    logic             m_pending;
    logic             m_sof_err;
    int               m_waddr;
    logic             m_rd_valid;
    logic [PIX_W-1:0] m_rd_data;
    bit               m_rd_known;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_bank     = 1'b0;
        m_pending  = 1'b0;
        m_sof_err  = 1'b0;
        m_waddr    = 0;
        m_rd_valid = 1'b0;
        m_rd_data  = '0;
        m_rd_known = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'(!m_pending));
        check({tag, "_pending"},  32'(bus.frame_pending), 32'(m_pending));
        check({tag, "_rd_bank"},  32'(bus.rd_bank), 32'(m_bank));
        check({tag, "_sof_err"},  32'(bus.sof_err), 32'(m_sof_err));
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'(m_rd_valid));
        if (m_rd_known) begin
            check({tag, "_rd_data"}, 32'(bus.rd_data), 32'(m_rd_data));
        end
    endtask

    // Drive one cycle of inputs, advance the model over the edge, then compare.
    task automatic cycle(input logic wv, input logic ws, input logic [PIX_W-1:0] wd,
                         input logic re, input logic [ADDR_W-1:0] ra, input logic fs);
        bit acc;
        bit swp;
        int a;
        bus.wr_valid   = wv;
        bus.wr_sof     = ws;
        bus.wr_data    = wd;
        bus.rd_en      = re;
        bus.rd_addr    = ra;
        bus.frame_sync = fs;
        acc = wv && !m_pending;
        swp = fs && m_pending;
        if (re) begin
            m_rd_valid = 1'b1;
            m_rd_data  = m_mem[m_bank][ra];
            m_rd_known = m_known[m_bank][ra];
        end else begin
            m_rd_valid = 1'b0;
        end
        if (acc) begin
            a = ws ? 0 : m_waddr;
            if (ws && m_waddr != 0) m_sof_err = 1'b1;
            m_mem[!m_bank][a]   = wd;
            m_known[!m_bank][a] = 1'b1;
            if (a == N - 1) begin
                m_pending = 1'b1;
                m_waddr   = 0;
            end else begin
                m_waddr = a + 1;
            end
        end
        if (swp) begin
            m_bank    = !m_bank;
            m_pending = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    task automatic write_frame(input logic [PIX_W-1:0] base);
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, i == 0, base + PIX_W'(i), 1'b0, '0, 1'b0);
        end
    endtask

    task automatic read_all(input logic [PIX_W-1:0] base);
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, ADDR_W'(i), 1'b0);
            check("rd_px", 32'(bus.rd_data), 32'(base + PIX_W'(i)));
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_sof     = 1'b0;
        bus.wr_data    = '0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        bus.frame_sync = 1'b0;
        bus2.wr_valid   = 1'b0;
        bus2.wr_sof     = 1'b0;
        bus2.wr_data    = '0;
        bus2.rd_en      = 1'b0;
        bus2.rd_addr    = '0;
        bus2.frame_sync = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) begin
                m_mem[b][i]   = '0;
                m_known[b][i] = 1'b0;
            end
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset_rd_data", 32'(bus.rd_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First frame fills bank 1 and stalls the writer.
        write_frame(12'h101);
        check("t1_pending", 32'(bus.frame_pending), 32'h1);
        check("t1_wr_ready", 32'(bus.wr_ready), 32'h0);
        cycle(1'b0, 1'b0, '0, 1'b1, 3'd0, 1'b0);
        check("t1_rd_bank", 32'(bus.rd_bank), 32'h0);

        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        check("t2_rd_bank", 32'(bus.rd_bank), 32'h1);
        check("t2_pending", 32'(bus.frame_pending), 32'h0);
        check("t2_wr_ready", 32'(bus.wr_ready), 32'h1);
        read_all(12'h101);

        // A held write while a frame is pending must not land.
        write_frame(12'h201);
        repeat (3) cycle(1'b1, 1'b0, 12'hFFF, 1'b0, '0, 1'b0);
        check("t3_wr_ready", 32'(bus.wr_ready), 32'h0);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        read_all(12'h201);

        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, i == 0, 12'h301 + 12'(i), 1'b0, '0, 1'b0);
        end
        cycle(1'b1, 1'b1, 12'h3AA, 1'b0, '0, 1'b0);
        check("t4_sof_err", 32'(bus.sof_err), 32'h1);
        for (int i = 1; i < N; i++) begin
            cycle(1'b1, 1'b0, 12'h3B0 + 12'(i), 1'b0, '0, 1'b0);
        end
        check("t4_pending", 32'(bus.frame_pending), 32'h1);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1, 3'd0, 1'b0);
        check("t4_px0", 32'(bus.rd_data), 32'h3AA);

        // Completion beat coincides with frame_sync: swap waits for the next pulse.
        for (int i = 0; i < N - 1; i++) begin
            cycle(1'b1, i == 0, 12'h501 + 12'(i), 1'b0, '0, 1'b0);
        end
        cycle(1'b1, 1'b0, 12'h508, 1'b0, '0, 1'b1);
        check("t5_no_swap", 32'(bus.rd_bank), 32'h1);
        check("t5_pending", 32'(bus.frame_pending), 32'h1);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        check("t5_swap", 32'(bus.rd_bank), 32'h0);
        read_all(12'h501);

        // Out-of-range reads on a 3x3 buffer (addresses 9..15 exist on the port).
        for (int i = 0; i < 9; i++) begin
            bus2.wr_valid = 1'b1;
            bus2.wr_sof   = (i == 0);
            bus2.wr_data  = 12'h900 + 12'(i);
            idle();
        end
        bus2.wr_valid = 1'b0;
        bus2.wr_sof   = 1'b0;
        check("oor_pending", 32'(bus2.frame_pending), 32'h1);
        bus2.frame_sync = 1'b1;
        idle();
        bus2.frame_sync = 1'b0;
        check("oor_rd_bank", 32'(bus2.rd_bank), 32'h1);
        bus2.rd_en = 1'b1;
        bus2.rd_addr = 4'd8;
        idle();
        check("oor_px8", 32'(bus2.rd_data), 32'h908);
        bus2.rd_addr = 4'd9;
        idle();
        check("oor_a9_data", 32'(bus2.rd_data), 32'h0);
        check("oor_a9_valid", 32'(bus2.rd_valid), 32'h1);
        bus2.rd_addr = 4'd0;
        idle();
        check("oor_px0", 32'(bus2.rd_data), 32'h900);
        bus2.rd_addr = 4'd15;
        idle();
        check("oor_a15_data", 32'(bus2.rd_data), 32'h0);
        bus2.rd_en = 1'b0;
        idle();
        check("oor_hold_valid", 32'(bus2.rd_valid), 32'h0);
        check("oor_hold_data", 32'(bus2.rd_data), 32'h0);

        // Asynchronous reset mid-frame while a read is in flight.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, i == 0, 12'h601 + 12'(i), 1'b1, ADDR_W'(i), 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rd_bank", 32'(bus.rd_bank), 32'h0);
        check("t6_pending", 32'(bus.frame_pending), 32'h0);
        check("t6_wr_ready", 32'(bus.wr_ready), 32'h1);
        check("t6_rd_valid", 32'(bus.rd_valid), 32'h0);
        check("t6_rd_data", 32'(bus.rd_data), 32'h0);
        check("t6_sof_err", 32'(bus.sof_err), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        write_frame(12'h701);
        check("t6_pending2", 32'(bus.frame_pending), 32'h1);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        check("t6_rd_bank2", 32'(bus.rd_bank), 32'h1);
        read_all(12'h701);

        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0,
                  PIX_W'($urandom),
                  $urandom_range(0, 1) == 1,
                  ADDR_W'($urandom_range(0, N - 1)),
                  $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
